pic_inta_sequencer: RTL and testbench

CPU-side counterpart of the 8259A priority resolver. It watches the PIC `INT` line, runs the two-pulse `INTA` acknowledge cycle, and captures the vector byte the PIC drives on the second pulse. It hands that vector to the processor core over a valid/ready handshake. It also writes non-specific EOI commands (OCW2 = 8'h20) back to the PIC on request, and sits between the PIC model and the host core in the system integration.

---
 rtl/pic_inta_sequencer.sv | 160 ++++++++++++++++
 tb/tb_pic_inta_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pic_inta_sequencer.sv
// CPU-side 8259A acknowledge sequencer: runs the two-pulse INTA cycle, captures the
// vector for the core over valid/ready, and issues queued non-specific EOI writes.
module pic_inta_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       int_req,
  input  logic       if_en,
  output logic       inta_n,
  input  logic [7:0] data_in,
  output logic       vec_valid,
  output logic [7:0] vec_data,
  input  logic       vec_ready,
  input  logic       eoi_req,
  output logic       ocw_wr_n,
  output logic [7:0] ocw_data,
  output logic       a0,
  output logic       eoi_done,
  output logic       busy
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_P1   = 3'd1;
  localparam logic [2:0] S_GAP  = 3'd2;
  localparam logic [2:0] S_P2   = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;
  localparam logic [2:0] S_EOI  = 3'd5;

  localparam logic [3:0] PW       = 4'(PULSE_W);
  localparam logic [3:0] GW       = 4'(GAP_W);
  localparam logic [7:0] OCW2_EOI = 8'h20;

  logic       sync1_q, sync2_q;
  logic [2:0] state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] holdoff_q, holdoff_d;
  logic [2:0] pend_q, pend_d;
  logic       eoi_dec;
  logic [7:0] vec_data_q, vec_data_d;
  logic       vec_valid_q, vec_valid_d;
  logic       inta_n_q, inta_n_d;
  logic       ocw_wr_n_q, ocw_wr_n_d;
  logic [7:0] ocw_data_q, ocw_data_d;
  logic       eoi_done_q, eoi_done_d;
  logic       busy_q, busy_d;
  logic       ocw_low;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 4'd1;
    vec_data_d  = vec_data_q;
    vec_valid_d = vec_valid_q;
    holdoff_d   = holdoff_q;
    eoi_dec     = 1'b0;
    if (holdoff_q != 2'd0) holdoff_d = holdoff_q - 2'd1;
    case (state_q)
      S_IDLE: begin
        cnt_d = 4'd0;
        // Queued EOIs win over a new acknowledge.
        if (pend_q != 3'd0)                              state_d = S_EOI;
        else if (sync2_q && if_en && holdoff_q == 2'd0) state_d = S_P1;
      end
      S_P1: if (cnt_q == PW - 4'd1) begin
        state_d = S_GAP;
        cnt_d   = 4'd0;
      end
      S_GAP: if (cnt_q == GW - 4'd1) begin
        state_d = S_P2;
        cnt_d   = 4'd0;
      end
      S_P2: if (cnt_q == PW - 4'd1) begin
        state_d     = S_HOLD;
        cnt_d       = 4'd0;
        vec_data_d  = data_in;
        vec_valid_d = 1'b1;
      end
      S_HOLD: begin
        cnt_d = 4'd0;
        if (vec_valid_q && vec_ready) begin
          state_d     = S_IDLE;
          vec_valid_d = 1'b0;
          // Covers the synchronizer depth so a stale INT cannot retrigger.
          holdoff_d   = 2'd2;
        end
      end
      S_EOI: if (cnt_q == PW) begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
        eoi_dec = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  always_comb begin
    pend_d = pend_q;
    case ({eoi_req, eoi_dec})
      2'b10:   if (pend_q != 3'd7) pend_d = pend_q + 3'd1;
      2'b01:   pend_d = pend_q - 3'd1;
      default: pend_d = pend_q;
    endcase
  end

  // Outputs are decoded from next state so they change on the same edge as the FSM.
  always_comb begin
    ocw_low    = (state_d == S_EOI) && (cnt_d < PW);
    inta_n_d   = !((state_d == S_P1) || (state_d == S_P2));
    ocw_wr_n_d = !ocw_low;
    ocw_data_d = ocw_low ? OCW2_EOI : 8'h00;
    eoi_done_d = (state_d == S_EOI) && (cnt_d == PW);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      holdoff_q   <= 2'd0;
      pend_q      <= 3'd0;
      vec_data_q  <= 8'h00;
      vec_valid_q <= 1'b0;
      inta_n_q    <= 1'b1;
      ocw_wr_n_q  <= 1'b1;
      ocw_data_q  <= 8'h00;
      eoi_done_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      sync1_q     <= int_req;
      sync2_q     <= sync1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      holdoff_q   <= holdoff_d;
      pend_q      <= pend_d;
      vec_data_q  <= vec_data_d;
      vec_valid_q <= vec_valid_d;
      inta_n_q    <= inta_n_d;
      ocw_wr_n_q  <= ocw_wr_n_d;
      ocw_data_q  <= ocw_data_d;
      eoi_done_q  <= eoi_done_d;
      busy_q      <= busy_d;
    end
  end

  assign inta_n    = inta_n_q;
  assign vec_valid = vec_valid_q;
  assign vec_data  = vec_data_q;
  assign ocw_wr_n  = ocw_wr_n_q;
  assign ocw_data  = ocw_data_q;
  assign a0        = 1'b0;
  assign eoi_done  = eoi_done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pic_inta_sequencer.sv
// Directed bench for pic_inta_sequencer with default PULSE_W = GAP_W = 2.
module tb_pic_inta_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       int_req, if_en, vec_ready, eoi_req;
  logic [7:0] data_in;
  logic       inta_n, vec_valid, ocw_wr_n, a0, eoi_done, busy;
  logic [7:0] vec_data, ocw_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pic_inta_sequencer #(.PULSE_W(2), .GAP_W(2)) dut (
    .clk(clk), .reset_n(reset_n), .int_req(int_req), .if_en(if_en),
    .inta_n(inta_n), .data_in(data_in), .vec_valid(vec_valid), .vec_data(vec_data),
    .vec_ready(vec_ready), .eoi_req(eoi_req), .ocw_wr_n(ocw_wr_n), .ocw_data(ocw_data),
    .a0(a0), .eoi_done(eoi_done), .busy(busy)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("strobe_sep", {7'd0, (inta_n === 1'b0 && ocw_wr_n === 1'b0)}, 8'd0);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while (busy !== 1'b0 && k < limit) begin
      tick();
      k++;
    end
    chk("idle_timeout", {7'd0, busy}, 8'd0);
  endtask

  task automatic wait_inta_low(input int limit);
    int k = 0;
    while (inta_n !== 1'b0 && k < limit) begin
      tick();
      k++;
    end
    chk("inta_timeout", {7'd0, inta_n}, 8'd0);
  endtask

  initial begin
    int  n_done, n_fall;
    logic prev_wr, saw_valid;
    reset_n = 1'b0; int_req = 1'b0; if_en = 1'b0; vec_ready = 1'b0;
    eoi_req = 1'b0; data_in = 8'h00;
    tick(); tick();
    chk("rst_inta_n", {7'd0, inta_n}, 8'd1);
    chk("rst_ocw_wr_n", {7'd0, ocw_wr_n}, 8'd1);
    chk("rst_ocw_data", ocw_data, 8'h00);
    chk("rst_a0", {7'd0, a0}, 8'd0);
    chk("rst_vec_valid", {7'd0, vec_valid}, 8'd0);
    chk("rst_vec_data", vec_data, 8'h00);
    chk("rst_eoi_done", {7'd0, eoi_done}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    reset_n = 1'b1;
    tick(); tick();

    // Basic acknowledge: int_req first sampled at edge 0.
    if_en = 1'b1; vec_ready = 1'b1; int_req = 1'b1;
    for (int k = 0; k <= 9; k++) begin
      tick();
      if (k == 3) int_req = 1'b0;
      if (k == 5) data_in = 8'h4B;
      chk("t1_inta_n", {7'd0, inta_n}, (k == 2 || k == 3 || k == 6 || k == 7) ? 8'd0 : 8'd1);
      if (k == 8) begin
        chk("t1_vec_valid", {7'd0, vec_valid}, 8'd1);
        chk("t1_vec_data", vec_data, 8'h4B);
        chk("t1_busy_hold", {7'd0, busy}, 8'd1);
        data_in = 8'hFF;
      end
      if (k == 9) begin
        chk("t1_busy_done", {7'd0, busy}, 8'd0);
        chk("t1_valid_done", {7'd0, vec_valid}, 8'd0);
        chk("t1_vec_keep", vec_data, 8'h4B);
      end
    end

    // Gating by if_en, then backpressure with INT held high throughout.
    if_en = 1'b0; int_req = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("gate_inta_n", {7'd0, inta_n}, 8'd1);
    end
    data_in = 8'hA5; vec_ready = 1'b0; if_en = 1'b1;
    tick();
    chk("gate_start", {7'd0, inta_n}, 8'd0);
    for (int k = 0; k < 6; k++) tick();
    chk("bp_valid", {7'd0, vec_valid}, 8'd1);
    chk("bp_data", vec_data, 8'hA5);
    data_in = 8'h11;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_stable", vec_data, 8'hA5);
      chk("bp_valid_hold", {7'd0, vec_valid}, 8'd1);
      chk("bp_no_inta", {7'd0, inta_n}, 8'd1);
    end
    vec_ready = 1'b1;
    tick();
    chk("stale_exit_valid", {7'd0, vec_valid}, 8'd0);
    chk("stale_exit_busy", {7'd0, busy}, 8'd0);
    chk("stale_h0_inta", {7'd0, inta_n}, 8'd1);
    tick();
    chk("stale_h1_inta", {7'd0, inta_n}, 8'd1);
    chk("stale_h1_busy", {7'd0, busy}, 8'd0);
    tick();
    chk("stale_h2_inta", {7'd0, inta_n}, 8'd1);
    tick();
    chk("stale_restart", {7'd0, inta_n}, 8'd0);
    int_req = 1'b0;
    wait_idle(30);

    // Single EOI from IDLE.
    eoi_req = 1'b1;
    tick();
    eoi_req = 1'b0;
    tick();
    chk("eoi_wr_n0", {7'd0, ocw_wr_n}, 8'd0);
    chk("eoi_data0", ocw_data, 8'h20);
    chk("eoi_a0", {7'd0, a0}, 8'd0);
    chk("eoi_busy", {7'd0, busy}, 8'd1);
    chk("eoi_done0", {7'd0, eoi_done}, 8'd0);
    tick();
    chk("eoi_wr_n1", {7'd0, ocw_wr_n}, 8'd0);
    chk("eoi_data1", ocw_data, 8'h20);
    tick();
    chk("eoi_wr_n_end", {7'd0, ocw_wr_n}, 8'd1);
    chk("eoi_data_end", ocw_data, 8'h00);
    chk("eoi_done_pulse", {7'd0, eoi_done}, 8'd1);
    tick();
    chk("eoi_done_clr", {7'd0, eoi_done}, 8'd0);
    chk("eoi_idle", {7'd0, busy}, 8'd0);

    // EOI requested during P1 waits for the acknowledge to finish.
    int_req = 1'b1;
    wait_inta_low(20);
    eoi_req = 1'b1;
    tick();
    eoi_req = 1'b0; int_req = 1'b0;
    saw_valid = 1'b0;
    for (int k = 0; k < 40 && ocw_wr_n !== 1'b0; k++) begin
      tick();
      if (vec_valid === 1'b1) saw_valid = 1'b1;
    end
    chk("eoi_after_hold", {7'd0, saw_valid}, 8'd1);
    chk("eoi_after_wr", {7'd0, ocw_wr_n}, 8'd0);
    wait_idle(30);

    // Nine requests during a stalled HOLD yield exactly seven writes.
    int_req = 1'b1; vec_ready = 1'b0;
    wait_inta_low(20);
    int_req = 1'b0;
    for (int k = 0; k < 30 && vec_valid !== 1'b1; k++) tick();
    chk("sat_hold", {7'd0, vec_valid}, 8'd1);
    eoi_req = 1'b1;
    for (int k = 0; k < 9; k++) tick();
    eoi_req = 1'b0;
    vec_ready = 1'b1;
    n_done = 0; n_fall = 0; prev_wr = ocw_wr_n;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (eoi_done === 1'b1) n_done++;
      if (prev_wr === 1'b1 && ocw_wr_n === 1'b0) n_fall++;
      prev_wr = ocw_wr_n;
    end
    chk("sat_done_cnt", 8'(n_done), 8'd7);
    chk("sat_write_cnt", 8'(n_fall), 8'd7);
    chk("sat_idle", {7'd0, busy}, 8'd0);

    // EOI pending and INT high together: write first, then acknowledge.
    eoi_req = 1'b1; int_req = 1'b1;
    tick();
    eoi_req = 1'b0;
    tick();
    chk("sim_eoi_first", {7'd0, ocw_wr_n}, 8'd0);
    chk("sim_no_inta", {7'd0, inta_n}, 8'd1);
    tick(); tick();
    chk("sim_eoi_done", {7'd0, eoi_done}, 8'd1);
    tick();
    chk("sim_gap_idle", {7'd0, busy}, 8'd0);
    tick();
    chk("sim_ack_next", {7'd0, inta_n}, 8'd0);
    int_req = 1'b0;
    tick(); tick();
    chk("rst_in_gap_inta", {7'd0, inta_n}, 8'd1);
    chk("rst_in_gap_busy", {7'd0, busy}, 8'd1);

    // Asynchronous reset during GAP.
    #2 reset_n = 1'b0;
    #1;
    chk("arst_inta_n", {7'd0, inta_n}, 8'd1);
    chk("arst_vec_valid", {7'd0, vec_valid}, 8'd0);
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_ocw_wr_n", {7'd0, ocw_wr_n}, 8'd1);
    tick(); tick();
    reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("post_rst_inta", {7'd0, inta_n}, 8'd1);
      chk("post_rst_busy", {7'd0, busy}, 8'd0);
      chk("post_rst_vdata", vec_data, 8'h00);
    end
    int_req = 1'b1;
    tick(); tick(); tick();
    chk("post_rst_ack", {7'd0, inta_n}, 8'd0);
    reset_n = 1'b0;
    #1;
    chk("arst_p1_inta", {7'd0, inta_n}, 8'd1);
    int_req = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    chk("final_idle", {7'd0, busy}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
